// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_responder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StBusy = 2'd1;
  localparam state_t StDone = 2'd2;

  localparam int unsigned LATENCY_MIN = 2;
  localparam int unsigned LATENCY_MAX = 15;

  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_responder_array.sv
// Synchronous single-port storage with write enable and registered read; contents are not reset.
module mem_array #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rdata_q;

  // Read-before-write: a simultaneous write is not visible on rdata until the next read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Latency-accurate load/store responder: accepts one request, stalls the pipeline for LATENCY
// cycles, then completes with a one-cycle Done pulse (and read data for loads).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Err
);

  state_t                  state_q, state_d;
  cnt_t                    cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [15:0]             data_q, data_d;
  logic                    wr_q, wr_d;
  logic [15:0]             dout_q, dout_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    req, legal, open;
  logic                    arr_we;
  logic [DEPTH_LOG2-1:0]   arr_addr;
  logic [15:0]             arr_rdata;

  // Upper address bits alias onto the array.
  logic unused_addr;
  assign unused_addr = ^Addr[15:DEPTH_LOG2+1];

  assign req   = Rd | Wr;
  assign legal = (Rd ^ Wr) & ~Addr[0];
  assign open  = (state_q != StBusy);
  assign Stall = ~open | legal;

  // While open, the array pre-reads the incoming address so a LATENCY=2 read has its word ready.
  assign arr_addr = open ? Addr[DEPTH_LOG2:1] : addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    arr_we  = 1'b0;
    case (state_q)
      StBusy: begin
        if (cnt_q == cnt_t'(1)) begin
          state_d = StDone;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (wr_q) begin
            arr_we = 1'b1;
          end else begin
            dout_d = arr_rdata;
          end
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: begin
        if (legal) begin
          state_d = StBusy;
          cnt_d   = cnt_t'(LATENCY - 1);
          addr_d  = Addr[DEPTH_LOG2:1];
          data_d  = DataIn;
          wr_d    = Wr;
        end else begin
          state_d = StIdle;
          err_d   = req;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  mem_array #(
    .AddrW(DEPTH_LOG2),
    .DataW(16)
  ) u_mem_array (
    .clk_i  (clk),
    .we_i   (arr_we),
    .addr_i (arr_addr),
    .wdata_i(data_q),
    .rdata_o(arr_rdata)
  );

  assign DataOut = dout_q;
  assign Done    = done_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with LATENCY=4, DEPTH_LOG2=10.
module tb_mem_responder;

  localparam int Lat = 4;

  logic        clk;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        Err;

  int n_tests;
  int n_fail;

  mem_responder #(
    .LATENCY   (Lat),
    .DEPTH_LOG2(10)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Addr   (Addr),
    .DataIn (DataIn),
    .Rd     (Rd),
    .Wr     (Wr),
    .DataOut(DataOut),
    .Done   (Done),
    .Stall  (Stall),
    .Err    (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a request for `hold` cycles (cycle 0 is the request cycle), then idles;
  // observes 10 cycles and records what the DUT did.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] din, input int hold,
                        output int stall_n, output int done_n, output int done_at,
                        output int err_n, output int err_at, output logic [15:0] dout);
    stall_n = 0; done_n = 0; done_at = -1; err_n = 0; err_at = -1; dout = 16'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (i < hold) begin
        Rd = rd; Wr = wr; Addr = addr; DataIn = din;
      end else begin
        Rd = 1'b0; Wr = 1'b0;
      end
      @(negedge clk);
      if (Stall) stall_n++;
      if (Done) begin done_n++; done_at = i; dout = DataOut; end
      if (Err) begin err_n++; err_at = i; end
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (DataOut !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", DataOut); end
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
    n_tests++; if (Err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", Err); end
    n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", Stall); end
    @(posedge clk); #2; rst = 1'b1;
  endtask

  task automatic test_write_read();
    int sn, dn, da, en, ea; logic [15:0] dv;
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, Lat, sn, dn, da, en, ea, dv);
    n_tests++; if (sn !== 4) begin n_fail++; $display("FAIL wr_stall_cycles got %0d want 4", sn); end
    n_tests++; if (dn !== 1 || da !== 4) begin n_fail++; $display("FAIL wr_done got n=%0d at=%0d want n=1 at=4", dn, da); end
    n_tests++; if (DataOut !== 16'h0) begin n_fail++; $display("FAIL wr_keeps_dout got %h want 0000", DataOut); end
    access(1'b1, 1'b0, 16'h0010, 16'h0000, Lat, sn, dn, da, en, ea, dv);
    n_tests++; if (sn !== 4) begin n_fail++; $display("FAIL rd_stall_cycles got %0d want 4", sn); end
    n_tests++; if (dn !== 1 || da !== 4) begin n_fail++; $display("FAIL rd_done got n=%0d at=%0d want n=1 at=4", dn, da); end
    n_tests++; if (dv !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data got %h want beef", dv); end
  endtask

  task automatic test_illegal_both();
    int sn, dn, da, en, ea; logic [15:0] dv;
    access(1'b0, 1'b1, 16'h0020, 16'h0F0F, Lat, sn, dn, da, en, ea, dv);
    access(1'b1, 1'b1, 16'h0020, 16'hDEAD, 1, sn, dn, da, en, ea, dv);
    n_tests++; if (en !== 1 || ea !== 1) begin n_fail++; $display("FAIL both_err got n=%0d at=%0d want n=1 at=1", en, ea); end
    n_tests++; if (sn !== 0) begin n_fail++; $display("FAIL both_stall got %0d want 0", sn); end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL both_done got %0d want 0", dn); end
    access(1'b1, 1'b0, 16'h0020, 16'h0000, Lat, sn, dn, da, en, ea, dv);
    n_tests++; if (dv !== 16'h0F0F) begin n_fail++; $display("FAIL both_old_value got %h want 0f0f", dv); end
  endtask

  task automatic test_misaligned();
    int sn, dn, da, en, ea; logic [15:0] dv;
    // DataOut is 0x0F0F from the previous read
    access(1'b1, 1'b0, 16'h0011, 16'h0000, 1, sn, dn, da, en, ea, dv);
    n_tests++; if (en !== 1 || ea !== 1) begin n_fail++; $display("FAIL mis_err got n=%0d at=%0d want n=1 at=1", en, ea); end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL mis_done got %0d want 0", dn); end
    n_tests++; if (DataOut !== 16'h0F0F) begin n_fail++; $display("FAIL mis_dout got %h want 0f0f", DataOut); end
  endtask

  task automatic test_back_to_back();
    int stall_rd; int done_rd_at; logic [15:0] dv; logic b2b_ok;
    stall_rd = 0; done_rd_at = -1; dv = 16'h0; b2b_ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (i < Lat) begin
        Rd = 1'b0; Wr = 1'b1; Addr = 16'h0040; DataIn = 16'h1234;
      end else if (i < 2 * Lat) begin
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0040; DataIn = 16'h0000;
      end else begin
        Rd = 1'b0; Wr = 1'b0;
      end
      @(negedge clk);
      if (i == Lat) b2b_ok = Done & Stall;
      if (i >= Lat && Stall) stall_rd++;
      if (i > Lat && Done) begin done_rd_at = i; dv = DataOut; end
    end
    n_tests++; if (b2b_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_overlap got %b want 1", b2b_ok); end
    n_tests++; if (stall_rd !== 4) begin n_fail++; $display("FAIL b2b_rd_stall got %0d want 4", stall_rd); end
    n_tests++; if (done_rd_at !== 2 * Lat) begin n_fail++; $display("FAIL b2b_rd_done_at got %0d want 8", done_rd_at); end
    n_tests++; if (dv !== 16'h1234) begin n_fail++; $display("FAIL b2b_rd_data got %h want 1234", dv); end
  endtask

  task automatic test_reset_mid_busy();
    int sn, dn, da, en, ea; logic [15:0] dv;
    access(1'b0, 1'b1, 16'h0008, 16'h1111, Lat, sn, dn, da, en, ea, dv);
    access(1'b1, 1'b0, 16'h0008, 16'h0000, Lat, sn, dn, da, en, ea, dv);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      Rd = 1'b0; Wr = 1'b1; Addr = 16'h0008; DataIn = 16'hAAAA;
    end
    @(negedge clk);
    n_tests++; if (DataOut !== 16'h1111 || Stall !== 1'b1) begin n_fail++;
      $display("FAIL pre_reset got dout=%h stall=%b want 1111 1", DataOut, Stall); end
    @(posedge clk); #2;
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0;
    #1;
    n_tests++; if (DataOut !== 16'h0 || Done !== 1'b0 || Err !== 1'b0 || Stall !== 1'b0) begin n_fail++;
      $display("FAIL mid_reset got dout=%h done=%b err=%b stall=%b want 0000 0 0 0", DataOut, Done, Err, Stall); end
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;
    access(1'b1, 1'b0, 16'h0008, 16'h0000, Lat, sn, dn, da, en, ea, dv);
    n_tests++; if (dn !== 1 || dv !== 16'h1111) begin n_fail++;
      $display("FAIL reset_no_commit got n=%0d data=%h want n=1 1111", dn, dv); end
  endtask

  task automatic test_alias();
    int sn, dn, da, en, ea; logic [15:0] dv;
    access(1'b0, 1'b1, 16'h0802, 16'h5555, Lat, sn, dn, da, en, ea, dv);
    access(1'b1, 1'b0, 16'h0002, 16'h0000, Lat, sn, dn, da, en, ea, dv);
    n_tests++; if (dn !== 1 || dv !== 16'h5555) begin n_fail++;
      $display("FAIL alias got n=%0d data=%h want n=1 5555", dn, dv); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
    test_reset();
    test_write_read();
    test_illegal_both();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_busy();
    test_alias();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
